// File: rtl/rs232_pkg.sv
// rs232_pkg: shared constants and helpers for the RS-232 receive path
package rs232_pkg;
  localparam bit LSB_FIRST = 1'b1;
  localparam bit MSB_FIRST = 1'b0;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/frame_bit_cnt.sv
// frame_bit_cnt: modulo-Width bit counter flagging the last bit of a frame
module frame_bit_cnt import rs232_pkg::*; #(
  parameter int Width = 9
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      inc,
  input  logic                      clr,
  output logic [clog2(Width)-1:0]   cnt,
  output logic                      last
);
  localparam int CntW = clog2(Width);
  assign last = cnt == CntW'(Width - 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sipo_frame_reg.sv
// sipo_frame_reg: serial-in/parallel-out frame register with valid/ready
// holding register and sticky overrun flag
module sipo_frame_reg import rs232_pkg::*; #(
  parameter int Width    = 9,
  parameter bit LsbFirst = LSB_FIRST
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             din_i,
  output logic [Width-1:0] dout_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             overrun_o,
  input  logic             ovr_clr_i
);
  localparam int CntW = clog2(Width);
  logic [Width-1:0] sh_q, sh_d;
  logic [CntW-1:0]  cnt_q;
  logic             last, done, free;
  frame_bit_cnt #(.Width(Width)) u_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .inc   (shift_i),
    .clr   (clr_i),
    .cnt   (cnt_q),
    .last  (last)
  );
  assign sh_d   = LsbFirst ? {din_i, sh_q[Width-1:1]} : {sh_q[Width-2:0], din_i};
  assign done   = shift_i & ~clr_i & last;
  // holding register can take a new word if empty or being drained this cycle
  assign free   = ~valid_o | ready_i;
  assign busy_o = cnt_q != '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sh_q <= '0;
    else if (clr_i) sh_q <= '0;
    else if (shift_i) sh_q <= last ? '0 : sh_d;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      dout_o  <= '0;
      valid_o <= 1'b0;
    end else if (done && free) begin
      dout_o  <= sh_d;
      valid_o <= 1'b1;
    end else if (valid_o && ready_i) valid_o <= 1'b0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) overrun_o <= 1'b0;
    else if (done && !free) overrun_o <= 1'b1;
    else if (ovr_clr_i) overrun_o <= 1'b0;
endmodule

// File: tb/tb_sipo_frame_reg.sv
// tb_sipo_frame_reg: directed and random checks of both bit orders against a
// frame-level reference model
module tb_sipo_frame_reg;
  localparam int W = 9;
  logic clk = 1'b0, rst_n = 1'b0;
  logic clr = 0, sh = 0, din = 0, rdy = 0, oclr = 0;
  logic [W-1:0] dl, dm;
  logic vl, vm, bl, bm, ol, om;
  int errors = 0, checks = 0;
  bit m_bits[$];
  logic [W-1:0] m_dl, m_dm;
  bit m_valid, m_ovr;

  always #5 clk = ~clk;

  sipo_frame_reg #(.Width(W), .LsbFirst(1'b1)) dut_l (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .shift_i(sh), .din_i(din),
    .dout_o(dl), .valid_o(vl), .ready_i(rdy), .busy_o(bl), .overrun_o(ol), .ovr_clr_i(oclr));
  sipo_frame_reg #(.Width(W), .LsbFirst(1'b0)) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .shift_i(sh), .din_i(din),
    .dout_o(dm), .valid_o(vm), .ready_i(rdy), .busy_o(bm), .overrun_o(om), .ovr_clr_i(oclr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_dl = '0; m_dm = '0; m_valid = 0; m_ovr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " dout_lsb"}, 32'(dl), 32'(m_dl));
    chk({tag, " dout_msb"}, 32'(dm), 32'(m_dm));
    chk({tag, " valid"}, {30'd0, vl, vm}, {30'd0, m_valid, m_valid});
    chk({tag, " busy"}, {30'd0, bl, bm}, {30'd0, m_bits.size() != 0, m_bits.size() != 0});
    chk({tag, " overrun"}, {30'd0, ol, om}, {30'd0, m_ovr, m_ovr});
  endtask

  task automatic step(input bit s, input bit d, input bit r, input bit c, input bit oc);
    bit loaded, set;
    sh = s; din = d; rdy = r; clr = c; oclr = oc;
    loaded = 0; set = 0;
    if (c) m_bits.delete();
    else if (s) begin
      m_bits.push_back(d);
      if (m_bits.size() == W) begin
        if (!m_valid || r) begin
          for (int i = 0; i < W; i++) begin
            m_dl[i] = m_bits[i];
            m_dm[W-1-i] = m_bits[i];
          end
          m_valid = 1; loaded = 1;
        end else set = 1;
        m_bits.delete();
      end
    end
    if (!loaded && m_valid && r) m_valid = 0;
    if (set) m_ovr = 1; else if (oc) m_ovr = 0;
    @(posedge clk);
    #1;
    sh = 0; din = 0; rdy = 0; clr = 0; oclr = 0;
  endtask

  task automatic frame(input logic [W-1:0] seq, input bit r_last, input string tag);
    for (int i = W - 1; i >= 0; i--) step(1, seq[i], (i == 0) ? r_last : 1'b0, 0, 0);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
    frame(9'b101001011, 0, "frame1");
    chk("plan lsb word", 32'(dl), 32'h1A5);
    chk("plan msb word", 32'(dm), 32'h14B);
    step(0, 0, 1, 0, 0);
    check_all("accept");
    chk("dout kept after accept", 32'(dm), 32'h14B);
    frame(9'b110011001, 0, "b2b first");
    frame(9'b001110101, 0, "b2b second");
    step(0, 0, 0, 0, 1);
    check_all("ovr clear");
    frame(9'b011111000, 1, "reload");
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    check_all("partial");
    step(1, 1, 0, 1, 0);
    check_all("clr beats shift");
    frame(9'h1FF, 1, "ones");
    chk("ones lsb", 32'(dl), 32'h1FF);
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 30) == 0, $urandom_range(0, 15) == 0);
      check_all("random");
    end
    frame(9'b100100111, 0, "pre reset");
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    chk("pre reset busy", {31'd0, bl}, 32'd1);
    rst_n = 0;
    model_reset();
    #1;
    check_all("async reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
